// File: rtl/shift_deserializer_if.sv
// Chunk-in / word-out stream bundle for shift_deserializer.
// The slave side is the deserializer and the master side is the producer/consumer.
interface shift_deserializer_if #(
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned SHIFT_WIDTH = 3
);

  logic                   in_valid;
  logic                   in_ready;
  logic [SHIFT_WIDTH-1:0] data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       data_out;
  logic                   pad_err;

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  data_out,
    input  pad_err
  );

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output data_out,
    output pad_err
  );

endinterface

// File: rtl/shift_deserializer.sv
// Assembles LSB-first SHIFT_WIDTH-bit chunks into a WIDTH-bit word with a ready/valid handshake.
// Define SHIFT_DESER_PAD_CHECK_EN to flag nonzero padding bits in the held word on pad_err.
module shift_deserializer #(
  parameter int unsigned WIDTH        = 64,
  parameter int unsigned PAR          = 1,
  parameter int unsigned d            = 2,
  parameter int unsigned SHIFT_WIDTH  = (d + 1) * PAR,
  parameter int unsigned PADDED_WIDTH = ((WIDTH + SHIFT_WIDTH - 1) / SHIFT_WIDTH) * SHIFT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  shift_deserializer_if.slave  bus
);

  localparam int unsigned NUM_CHUNKS = PADDED_WIDTH / SHIFT_WIDTH;
  localparam int unsigned CNT_W      = $clog2(NUM_CHUNKS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CHUNKS - 1);

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [PADDED_WIDTH-1:0] shreg_q, shreg_d;
  logic [PADDED_WIDTH-1:0] shifted_c;
  logic                    in_ready_c;
  logic                    accept_c;

  // New chunk enters at the top so the first chunk ends up in the LSBs.
  generate
    if (NUM_CHUNKS == 1) begin : g_single
      assign shifted_c = bus.data_in;
    end else begin : g_multi
      assign shifted_c = {bus.data_in, shreg_q[PADDED_WIDTH-1:SHIFT_WIDTH]};
    end
  endgenerate

  always_comb begin
    in_ready_c = (state_q == COLLECT) || ((state_q == FULL) && bus.out_ready);
    accept_c   = bus.in_valid && in_ready_c;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == FULL);
  assign bus.data_out  = shreg_q[WIDTH-1:0];

  // Next-state: clear overrides any accept or release in the same cycle.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shreg_d = shreg_q;

    unique case (state_q)
      COLLECT: begin
        if (accept_c) begin
          shreg_d = shifted_c;
          if (count_q == LAST_CNT) begin
            state_d = FULL;
            count_d = '0;
          end else begin
            count_d = CNT_W'(count_q + CNT_W'(1));
          end
        end
      end
      FULL: begin
        if (bus.out_ready) begin
          if (accept_c) begin
            shreg_d = shifted_c;
            if (NUM_CHUNKS == 1) begin
              state_d = FULL;
              count_d = '0;
            end else begin
              state_d = COLLECT;
              count_d = CNT_W'(1);
            end
          end else begin
            state_d = COLLECT;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = COLLECT;
        count_d = '0;
      end
    endcase

    if (clear) begin
      state_d = COLLECT;
      count_d = '0;
      shreg_d = shreg_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      count_q <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shreg_q <= shreg_d;
    end
  end

`ifdef SHIFT_DESER_PAD_CHECK_EN
  generate
    if (PADDED_WIDTH > WIDTH) begin : g_pad
      logic pad_err_q;
      logic load_full_c;

      // Only the final chunk of a word can move the FSM into FULL via an accept.
      assign load_full_c = accept_c && (state_d == FULL);

      always_ff @(posedge clk) begin
        if (reset) begin
          pad_err_q <= 1'b0;
        end else if (load_full_c) begin
          pad_err_q <= |shifted_c[PADDED_WIDTH-1:WIDTH];
        end else if (state_d != FULL) begin
          pad_err_q <= 1'b0;
        end
      end

      assign bus.pad_err = pad_err_q;
    end else begin : g_no_pad
      assign bus.pad_err = 1'b0;
    end
  endgenerate
`else
  assign bus.pad_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deserializer.sv
// Randomized and directed bench for shift_deserializer against a chunk-queue word model.
module tb_shift_deserializer;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned SW    = 3;
  localparam int unsigned NCH   = 22;
  localparam int unsigned PW    = 66;

  logic clk = 1'b0;
  logic reset;
  logic clear;

  shift_deserializer_if #(.WIDTH(WIDTH), .SHIFT_WIDTH(SW)) bus ();

  shift_deserializer #(
    .WIDTH (WIDTH),
    .PAR   (1),
    .d     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: chunks of the word in progress, plus the word currently offered.
  bit          m_init = 1'b0;
  bit          m_full = 1'b0;
  logic [2:0]  m_q[$];
  logic [63:0] m_word = '0;
  bit          m_pad  = 1'b0;
  bit          last_acc = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] assemble();
    logic [PW-1:0] w;
    w = '0;
    foreach (m_q[i]) w = w | (PW'(m_q[i]) << (SW * i));
    return w;
  endfunction

  task automatic cycle(input bit rst, input bit clr, input bit iv, input logic [2:0] di, input bit ordy);
    bit            exp_rdy;
    bit            acc;
    logic [PW-1:0] w;
    @(negedge clk);
    reset         = rst;
    clear         = clr;
    bus.in_valid  = iv;
    bus.data_in   = di;
    bus.out_ready = ordy;
    #1;
    exp_rdy = !m_full || ordy;
    if (m_init) begin
      chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_full));
      if (m_full) begin
        chk("data_out", bus.data_out, m_word);
        chk("pad_err", 64'(bus.pad_err), 64'(m_pad));
      end else begin
        chk("pad_err_idle", 64'(bus.pad_err), 64'd0);
      end
    end
    acc = 1'b0;
    if (rst) begin
      m_init = 1'b1;
      m_full = 1'b0;
      m_pad  = 1'b0;
      m_q.delete();
    end else if (clr) begin
      m_full = 1'b0;
      m_pad  = 1'b0;
      m_q.delete();
    end else begin
      acc = iv && exp_rdy;
      if (m_full && ordy) m_full = 1'b0;
      if (acc) begin
        m_q.push_back(di);
        if (m_q.size() == NCH) begin
          w      = assemble();
          m_word = w[63:0];
`ifdef SHIFT_DESER_PAD_CHECK_EN
          m_pad  = |w[PW-1:WIDTH];
`else
          m_pad  = 1'b0;
`endif
          m_full = 1'b1;
          m_q.delete();
        end
      end
    end
    last_acc = acc;
  endtask

  task automatic send_word(input logic [PW-1:0] w, input bit ordy, output int used);
    int idx;
    int budget;
    idx    = 0;
    budget = 200;
    used   = 0;
    while (idx < NCH && budget > 0) begin
      cycle(1'b0, 1'b0, 1'b1, w[SW*idx +: SW], ordy);
      if (last_acc) idx++;
      budget--;
      used++;
    end
    chk("send_budget", 64'(idx), 64'(NCH));
  endtask

  task automatic send_partial(input int n);
    int idx;
    int budget;
    idx    = 0;
    budget = 200;
    while (idx < n && budget > 0) begin
      cycle(1'b0, 1'b0, 1'b1, 3'($urandom), 1'b1);
      if (last_acc) idx++;
      budget--;
    end
    chk("partial_budget", 64'(idx), 64'(n));
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 3'($urandom), ordy);
  endtask

  initial begin
    int            used;
    logic [PW-1:0] w;
    logic [63:0]   rnd;

    reset         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.out_ready = 1'b0;

    cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1, 1'b0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Back-to-back word with the consumer always ready.
    send_word({2'b00, 64'h0123_4567_89AB_CDEF}, 1'b1, used);
    chk("w1_cycles", 64'(used), 64'(NCH));
    idle(1, 1'b1);
    chk("w1_valid", 64'(bus.out_valid), 64'd1);
    chk("w1_data", bus.data_out, 64'h0123_4567_89AB_CDEF);
    chk("w1_pad", 64'(bus.pad_err), 64'd0);
    idle(1, 1'b1);
    chk("w1_released", 64'(bus.out_valid), 64'd0);

    // Backpressure: word held for five cycles, then a single release.
    send_word({2'b00, 64'hDEAD_BEEF_CAFE_F00D}, 1'b0, used);
    idle(5, 1'b0);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_data", bus.data_out, 64'hDEAD_BEEF_CAFE_F00D);
    idle(1, 1'b1);
    idle(1, 1'b1);
    chk("bp_single_release", 64'(bus.out_valid), 64'd0);

    // Release and first chunk of the next word in the same cycle.
    send_word({2'b00, 64'h1111_2222_3333_4444}, 1'b0, used);
    idle(1, 1'b0);
    send_word({2'b00, 64'h5555_6666_7777_8888}, 1'b1, used);
    chk("overlap_cycles", 64'(used), 64'(NCH));
    idle(1, 1'b0);
    chk("overlap_data", bus.data_out, 64'h5555_6666_7777_8888);
    idle(1, 1'b1);

    // Clear mid-word drops the partial word and the chunk offered with it.
    send_partial(10);
    cycle(1'b0, 1'b1, 1'b1, 3'b111, 1'b1);
    send_word({2'b00, 64'hFFFF_0000_FFFF_0000}, 1'b1, used);
    idle(1, 1'b0);
    chk("clear_data", bus.data_out, 64'hFFFF_0000_FFFF_0000);
    idle(1, 1'b1);

    // Nonzero padding in the final chunk.
    rnd = {$urandom, $urandom};
    w   = {3'b111, rnd[62:0]};
    send_word(w, 1'b1, used);
    idle(1, 1'b0);
    chk("pad_data_msb", 64'(bus.data_out[63]), 64'd1);
`ifdef SHIFT_DESER_PAD_CHECK_EN
    chk("pad_flag", 64'(bus.pad_err), 64'd1);
`else
    chk("pad_flag", 64'(bus.pad_err), 64'd0);
`endif
    idle(1, 1'b1);

    // Reset mid-word.
    send_partial(7);
    cycle(1'b1, 1'b0, 1'b1, 3'b101, 1'b1);
    idle(1, 1'b0);
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    send_word({2'b00, 64'hA5A5_5A5A_0F0F_F0F0}, 1'b1, used);
    idle(1, 1'b0);
    chk("midrst_data", bus.data_out, 64'hA5A5_5A5A_0F0F_F0F0);
    idle(1, 1'b1);

    // Random traffic with occasional clear and reset.
    for (int i = 0; i < 4000; i++) begin
      cycle(($urandom % 400) == 0, ($urandom % 90) == 0, ($urandom % 4) != 0,
            3'($urandom), ($urandom % 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_deserializer.md
SHIFT_DESERIALIZER -- requirements
Module: shift_deserializer

Interface
REQ-001 SHALL have parameter WIDTH, default 64, assembled word width in bits.
REQ-002 SHALL have parameter PAR, default 1, bits per share per chunk.
REQ-003 SHALL have parameter d, default 2, masking order; shares per bit = d+1.
REQ-004 SHALL have parameter SHIFT_WIDTH, default (d+1)*PAR, chunk width.
REQ-005 SHALL have parameter PADDED_WIDTH, default ceil(WIDTH/SHIFT_WIDTH)*SHIFT_WIDTH, internal register width.
REQ-006 SHALL have derived localparam NUM_CHUNKS = PADDED_WIDTH/SHIFT_WIDTH, with counter width $clog2(NUM_CHUNKS+1).
REQ-007 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port clear  input  1  synchronous abort of the word in progress.
REQ-010 SHALL have port in_valid  input  1  chunk on data_in is valid.
REQ-011 SHALL have port in_ready  output  1  block accepts a chunk this cycle.
REQ-012 SHALL have port data_in  input  SHIFT_WIDTH  incoming chunk.
REQ-013 SHALL have port out_valid  output  1  assembled word available.
REQ-014 SHALL have port out_ready  input  1  consumer takes the word.
REQ-015 SHALL have port data_out  output  WIDTH  assembled word.
REQ-016 SHALL have port pad_err  output  1  nonzero padding seen in the held word.

Function
REQ-017 SHALL accept a chunk only on a cycle with in_valid && in_ready (the "accept" event).
REQ-018 SHALL receive chunks LSB-first: the first accepted chunk of a word becomes bits [SHIFT_WIDTH-1:0] of the padded word.
REQ-019 SHALL perform each accept as a right shift with the new chunk inserted at the top: reg <= {data_in, reg[PADDED_WIDTH-1:SHIFT_WIDTH]}.
REQ-020 SHALL implement a two-state FSM with states COLLECT and FULL.
REQ-021 SHALL, in COLLECT, drive in_ready=1 and out_valid=0, and increment the chunk count on each accept.
REQ-022 SHALL, in COLLECT, on the accept that brings the count to NUM_CHUNKS, go to FULL and clear the count to 0; out_valid=1 from the next cycle.
REQ-023 SHALL, in FULL, drive out_valid=1 and data_out = reg[WIDTH-1:0]; padding bits [PADDED_WIDTH-1:WIDTH] are discarded.
REQ-024 SHALL hold data_out, out_valid and pad_err stable in FULL until out_ready=1.
REQ-025 SHALL drive in_ready = (state==COLLECT) || (state==FULL && out_ready); the combinational out_ready-to-in_ready path is permitted.
REQ-026 SHALL, in FULL with out_ready=1 and no accept, release the word and return to COLLECT with count 0.
REQ-027 SHALL, in FULL with out_ready=1 and an accept, release the word and treat the chunk as chunk 0 of the next word: count=1, state COLLECT; if NUM_CHUNKS==1, stay in FULL.
REQ-028 SHALL, on clear=1, go to COLLECT with count 0 and out_valid=0, drop any chunk offered that cycle, and leave register contents don't-care.
REQ-029 SHALL give clear priority over accept and release; an in_valid held high during clear has no effect.
REQ-030 SHALL have a latency of 1 cycle from the final accept to out_valid=1, with zero-bubble throughput of one chunk per cycle.

Reset
REQ-031 SHALL, on reset=1 at a rising edge, set state=COLLECT, count=0, register=0, out_valid=0, pad_err=0, with in_ready=1 the following cycle.
REQ-032 SHALL give reset priority over clear and all handshakes; reset mid-word discards partial data.

Configuration
REQ-033 SHALL support the macro SHIFT_DESER_PAD_CHECK_EN.
REQ-034 SHALL, when SHIFT_DESER_PAD_CHECK_EN is defined, register pad_err = |reg[PADDED_WIDTH-1:WIDTH] on entry to FULL, valid while out_valid=1 and 0 otherwise.
REQ-035 SHALL tie pad_err to 0 when PADDED_WIDTH==WIDTH or when SHIFT_DESER_PAD_CHECK_EN is undefined, with no check logic instantiated.

Verification (WIDTH=64, PAR=1, d=2: SHIFT_WIDTH=3, PADDED_WIDTH=66, NUM_CHUNKS=22)
REQ-036 SHALL cover: 22 back-to-back chunks of the zero-padded 64'h0123_4567_89AB_CDEF, LSB-first, out_ready=1 -> out_valid=1 exactly one cycle after the 22nd accept, data_out=64'h0123_4567_89AB_CDEF, pad_err=0.
REQ-037 SHALL cover: word complete with out_ready=0 for 5 cycles -> in_ready=0, data_out held; out_ready=1 -> single release.
REQ-038 SHALL cover: out_ready=1 and in_valid=1 in the same FULL cycle -> word released, count=1, next word assembles correctly with no lost cycle.
REQ-039 SHALL cover: clear after 10 accepts, then a full word 64'hFFFF_0000_FFFF_0000 -> output equals the second word only.
REQ-040 SHALL cover: with SHIFT_DESER_PAD_CHECK_EN defined, 22nd chunk = 3'b111 -> pad_err=1 and data_out[63]=1; without the macro, pad_err=0.
REQ-041 SHALL cover: reset asserted after 7 accepts -> next cycle out_valid=0, in_ready=1, and a following full word decodes correctly.
